// File: rtl/mult_shift_add_ctrl.sv
// Control FSM for the 32-bit shift-add multiplier: sequences IDLE -> LOAD -> RUN -> DONE.
// Optional build macro MULT_CTRL_EARLY_TERM_EN ends RUN as soon as the B register is zero.
module mult_shift_add_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iStart,
    input  logic iB_LSB,
    input  logic iB_Zero,
    output logic b_sel,
    output logic a_sel,
    output logic add_sel,
    output logic prod_sel,
    output logic Shift_Enable,
    output logic oBusy,
    output logic oDone
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_finish;

`ifdef MULT_CTRL_EARLY_TERM_EN
    // Once B is empty the remaining iterations cannot change Prod.
    assign w_finish = (r_cnt == LastCnt) || iB_Zero;
`else
    logic w_unused_b_zero;
    assign w_unused_b_zero = iB_Zero;
    assign w_finish        = (r_cnt == LastCnt);
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        b_sel        = 1'b1;
        a_sel        = 1'b1;
        prod_sel     = 1'b1;
        add_sel      = 1'b0;
        Shift_Enable = 1'b0;
        oBusy        = 1'b0;
        oDone        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (iStart) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                b_sel        = 1'b0;
                a_sel        = 1'b0;
                prod_sel     = 1'b0;
                oBusy        = 1'b1;
                w_cnt_next   = '0;
                w_state_next = StRun;
            end
            StRun: begin
                Shift_Enable = 1'b1;
                oBusy        = 1'b1;
                add_sel      = iB_LSB;
                // Counter holds on the final iteration so it never passes WIDTH-1.
                if (w_finish) begin
                    w_state_next = StDone;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDone: begin
                oDone        = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule
